// File: rtl/ct_rst_pkg.sv
// Shared definitions for the core reset sequencer: FSM states, unit indices, flush mask.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ct_rst_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_RST   = 3'd0,
      ST_HOLD  = 3'd1,
      ST_REL   = 3'd2,
      ST_RUN   = 3'd3,
      ST_FLUSH = 3'd4
   } seq_state_t;

   // Unit positions within unit_rst_b; release order follows index order
   localparam int UNIT_IFU      = 0;
   localparam int UNIT_IDU      = 1;
   localparam int UNIT_LSU      = 2;
   localparam int UNIT_FPU      = 3;
   localparam int UNIT_MMU      = 4;
   localparam int UNIT_HAD      = 5;
   localparam int UNIT_IDU_ARCH = 6;

   localparam int DEF_NUM_UNITS = 7;

   // Everything except the architectural IDU state is wiped by fence.t
   localparam logic [DEF_NUM_UNITS-1:0] DEF_UARCH_MASK = 7'b0111111;

   // Bits needed to hold max_val, never less than one
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/ct_rst_seq_ctrl_if.sv
// Bundle of the sequencer's flush handshake and reset/status outputs.
// Latency: n/a (wires only).
// Backpressure: fencet_req is a level held by the requester until fencet_ack.
interface ct_rst_seq_ctrl_if #(
   parameter int NUM_UNITS = 7
);
   logic                 fencet_req;
   logic                 fencet_ack;
   logic [NUM_UNITS-1:0] unit_rst_b;
   logic                 seq_busy;
   logic                 seq_done;

   // Sequencer side
   modport slave (
      input  fencet_req,
      output fencet_ack,
      output unit_rst_b,
      output seq_busy,
      output seq_done
   );

   // Requester / consumer side
   modport master (
      output fencet_req,
      input  fencet_ack,
      input  unit_rst_b,
      input  seq_busy,
      input  seq_done
   );
endinterface

// File: rtl/ct_rst_sync.sv
// Reset synchronizer: asserts asynchronously, releases after SYNC_STAGES clock edges.
// Latency: SYNC_STAGES rising edges from async_corerst_b rise to sync_rst_b high.
// Backpressure: none.
module ct_rst_sync #(
   parameter int SYNC_STAGES = 3
) (
   input  logic forever_coreclk,
   input  logic async_corerst_b,
   output logic sync_rst_b
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Shift a one in from the bottom once reset is released
   always_ff @(posedge forever_coreclk or negedge async_corerst_b) begin
      if (!async_corerst_b) begin
         sync_q <= '0;
      end else begin
         sync_q <= (sync_q << 1) | SYNC_STAGES'(1);
      end
   end

   assign sync_rst_b = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ct_rst_seq_ctrl.sv
// Core reset sequencer: staged per-unit reset release after power-on and after fence.t flush.
// Latency: unit i released SYNC_STAGES+HOLD_CYC+1+i*GAP_CYC edges after reset release; flush ack HOLD_CYC+(NUM_UNITS-1)*GAP_CYC edges after req.
// Backpressure: fencet_req is only taken in RUN and not in the ack cycle; otherwise it simply waits.
module ct_rst_seq_ctrl
   import ct_rst_pkg::*;
#(
   parameter int                   NUM_UNITS   = DEF_NUM_UNITS,
   parameter int                   SYNC_STAGES = 3,
   parameter int                   HOLD_CYC    = 8,
   parameter int                   GAP_CYC     = 4,
   parameter logic [NUM_UNITS-1:0] UARCH_MASK  = NUM_UNITS'(DEF_UARCH_MASK)
) (
   input  logic                    forever_coreclk,
   input  logic                    async_corerst_b,
   input  logic                    pad_yy_scan_mode,
   input  logic                    pad_yy_scan_rst_b,
   ct_rst_seq_ctrl_if.slave        bus
);

   localparam int HOLD_W = cnt_width(HOLD_CYC - 1);
   localparam int GAP_W  = cnt_width(GAP_CYC - 1);
   localparam int IDX_W  = cnt_width(NUM_UNITS - 1);

   localparam logic [HOLD_W-1:0] HOLD_LD  = HOLD_W'(HOLD_CYC - 1);
   localparam logic [GAP_W-1:0]  GAP_LD   = GAP_W'(GAP_CYC - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_UNITS - 1);

   logic                 sync_rst_b;

   seq_state_t           state_q,    state_d;
   logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
   logic [GAP_W-1:0]     gap_cnt_q,  gap_cnt_d;
   logic [IDX_W-1:0]     idx_q,      idx_d;
   logic [IDX_W-1:0]     idx_inc;
   logic [NUM_UNITS-1:0] unit_rst_q, unit_rst_d;
   logic                 flush_pend_q, flush_pend_d;
   logic                 fencet_ack_q, fencet_ack_d;

   ct_rst_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .forever_coreclk (forever_coreclk),
      .async_corerst_b (async_corerst_b),
      .sync_rst_b      (sync_rst_b)
   );

   assign idx_inc = idx_q + IDX_W'(1);

   // Sequencer state, counters and the unit reset flops themselves
   always_ff @(posedge forever_coreclk or negedge async_corerst_b) begin
      if (!async_corerst_b) begin
         state_q      <= ST_RST;
         hold_cnt_q   <= '0;
         gap_cnt_q    <= '0;
         idx_q        <= '0;
         unit_rst_q   <= '0;
         flush_pend_q <= 1'b0;
         fencet_ack_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         idx_q        <= idx_d;
         unit_rst_q   <= unit_rst_d;
         flush_pend_q <= flush_pend_d;
         fencet_ack_q <= fencet_ack_d;
      end
   end

   // Next-state: hold, then release one unit per gap, then run / accept flushes
   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      idx_d        = idx_q;
      unit_rst_d   = unit_rst_q;
      flush_pend_d = flush_pend_q;
      fencet_ack_d = 1'b0;

      case (state_q)
         ST_RST: begin
            if (sync_rst_b) begin
               state_d    = ST_HOLD;
               hold_cnt_d = HOLD_LD;
            end
         end

         ST_HOLD, ST_FLUSH: begin
            if (hold_cnt_q == '0) begin
               unit_rst_d[UNIT_IFU] = 1'b1;
               idx_d                = '0;
               gap_cnt_d            = GAP_LD;
               if (NUM_UNITS == 1) begin
                  // Single unit: its release is also the last one
                  state_d      = ST_RUN;
                  fencet_ack_d = flush_pend_q;
                  flush_pend_d = 1'b0;
               end else begin
                  state_d = ST_REL;
               end
            end else begin
               hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end
         end

         ST_REL: begin
            if (gap_cnt_q == '0) begin
               // Setting a bit that is already high (unmasked unit) is harmless
               unit_rst_d[idx_inc] = 1'b1;
               idx_d               = idx_inc;
               gap_cnt_d           = GAP_LD;
               if (idx_inc == LAST_IDX) begin
                  state_d      = ST_RUN;
                  fencet_ack_d = flush_pend_q;
                  flush_pend_d = 1'b0;
               end
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
         end

         ST_RUN: begin
            // The ack cycle masks the still-high req so one request gives one flush
            if (bus.fencet_req && !fencet_ack_q) begin
               unit_rst_d   = unit_rst_q & ~UARCH_MASK;
               state_d      = ST_FLUSH;
               hold_cnt_d   = HOLD_LD;
               flush_pend_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_RST;
         end
      endcase
   end

   // Scan mux is the only logic after the reset flops
   assign bus.unit_rst_b = pad_yy_scan_mode ? {NUM_UNITS{pad_yy_scan_rst_b}} : unit_rst_q;
   assign bus.fencet_ack = fencet_ack_q & ~pad_yy_scan_mode;
   assign bus.seq_busy   = (state_q != ST_RUN);
   assign bus.seq_done   = (state_q == ST_RUN);

endmodule

// File: doc/ct_rst_seq_ctrl.md
CT_RST_SEQ_CTRL -- requirements
Module: ct_rst_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 7, number of unit reset outputs: bit0 IFU, 1 IDU, 2 LSU, 3 FPU, 4 MMU, 5 HAD, 6 IDU_ARCH.
REQ-002 SHALL have parameter SYNC_STAGES, default 3, deassertion synchronizer depth.
REQ-003 SHALL have parameter HOLD_CYC, default 8, minimum in-reset hold cycles (>=1).
REQ-004 SHALL have parameter GAP_CYC, default 4, cycles between successive unit releases (>=1).
REQ-005 SHALL have parameter UARCH_MASK, default 7'b0111111, units reset by fence.t flush.
REQ-006 forever_coreclk  in  1  core clock, rising edge.
REQ-007 async_corerst_b  in  1  reset, asynchronous, active-low.
REQ-008 pad_yy_scan_mode  in  1  scan mode select.
REQ-009 pad_yy_scan_rst_b  in  1  scan reset, drives all unit resets in scan mode.
REQ-010 fencet_req  in  1  fence.t uarch-flush request, level, held until ack.
REQ-011 fencet_ack  out  1  one-cycle flush-complete pulse.
REQ-012 unit_rst_b  out  NUM_UNITS  per-unit active-low resets.
REQ-013 seq_busy  out  1  high whenever state != RUN.
REQ-014 seq_done  out  1  high in RUN (all units released).

Function
REQ-015 SHALL synchronize deassertion of async_corerst_b through SYNC_STAGES flops (async assert, sync release) into sync_rst_b.
REQ-016 FSM states SHALL be RST, HOLD, REL, RUN, FLUSH.
REQ-017 RST: on first edge with sync_rst_b=1 -> HOLD, hold_cnt=HOLD_CYC-1.
REQ-018 HOLD/FLUSH: hold_cnt decrements each edge; at edge with hold_cnt=0 -> REL, idx=0, unit_rst_b[0] set to 1, gap_cnt=GAP_CYC-1.
REQ-019 REL: gap_cnt decrements; at edge with gap_cnt=0 set unit_rst_b[idx+1], idx++, reload gap_cnt; release of last index (NUM_UNITS-1) SHALL move to RUN on the same edge.
REQ-020 Setting an already-high bit SHALL be a no-op; REL timing SHALL NOT depend on which bits were low.
REQ-021 With defaults, unit_rst_b[i] SHALL rise at edge SYNC_STAGES+HOLD_CYC+1+i*GAP_CYC after async_corerst_b rise (12,16,...,36); RUN at edge 36.
REQ-022 RUN: fencet_req=1 sampled at edge E SHALL clear unit_rst_b bits in UARCH_MASK at E, enter FLUSH with hold_cnt=HOLD_CYC-1; unmasked bits stay 1.
REQ-023 fencet_ack SHALL pulse for exactly the one cycle following re-entry to RUN from a flush; never after power-on sequence.
REQ-024 fencet_req SHALL be ignored outside RUN and in the cycle fencet_ack is high; a req still high the cycle after ack SHALL start a new flush.
REQ-025 In scan mode every unit_rst_b bit SHALL equal pad_yy_scan_rst_b combinationally; FSM continues internally; fencet_ack forced 0.
REQ-026 Counter widths SHALL be $clog2 of their max value, min 1 bit; no wrap beyond loaded value.

Reset
REQ-027 async_corerst_b low SHALL immediately force: sync flops 0, state RST, all unit_rst_b 0, counters/idx 0, fencet_ack 0, seq_busy 1, seq_done 0.
REQ-028 Reset mid-REL or mid-FLUSH SHALL abort; pending flush dropped, no ack issued; full power-on sequence restarts.
REQ-029 unit_rst_b SHALL be glitch-free flop outputs (scan mux the only logic after the flop).

Structure
REQ-030 State encoding, unit index constants (IFU..IDU_ARCH) and default UARCH_MASK SHALL live in shared package ct_rst_pkg.
REQ-031 Synchronizer SHALL be sub-module ct_rst_sync (parameter SYNC_STAGES); everything else flat.

Verification
REQ-032 Power-on: release async_corerst_b at edge 0, defaults -> unit_rst_b bit i rises at edge 12+4i, seq_done at 36, fencet_ack stays 0.
REQ-033 Flush: in RUN, fencet_req=1 at edge E -> bits 0-5 low at E, bit6 stays 1, bits re-release E+8+4i, fencet_ack single pulse at E+32.
REQ-034 Back-to-back: fencet_req held high through ack -> second flush starts edge after ack pulse.
REQ-035 Mid-sequence reset: assert async_corerst_b low at REL edge 20 -> all outputs 0 same cycle; after release, sequence restarts from edge 12 timing, no ack.
REQ-036 Scan: pad_yy_scan_mode=1, toggle pad_yy_scan_rst_b 0/1 -> all unit_rst_b follow combinationally, fencet_ack 0.
REQ-037 Request outside RUN: fencet_req pulsed during HOLD -> no effect, no ack.
